leading_zero_counter: RTL and testbench
=======================================

Name: leading_zero_counter

Overview:
- Registered leading-zero counter over a WIDTH-bit unsigned word.
- Reports how many consecutive zero bits precede the most-significant 1, counting down from bit WIDTH-1.
- Feeds the normalisation shift of the fixed-point reciprocal unit, which scales its input into the [0.5,1) range.
- Default WIDTH=24 covers an SQ12.12 magnitude.

Parameters:
- WIDTH, 24, input word width in bits (M+N of the fixed-point format); legal range 2..64.
- CNT_W, 5, count output width; must satisfy 2^CNT_W > WIDTH; default 5 holds the full range 0..24.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  i_data is valid this cycle and is to be counted.
- i_data  input  WIDTH  unsigned word to be counted; bit WIDTH-1 is the MSB.
- o_valid  output  1  o_lzc and o_zero hold a result; asserted one cycle after i_valid.
- o_lzc  output  CNT_W  leading-zero count of the captured word.
- o_zero  output  1  captured word was all zeros.

Behaviour:
- Reset is asynchronous and active-high. While reset=1, and immediately on its assertion: o_valid=0, o_lzc=0, o_zero=0.
- Reset asserted mid-operation discards any pending result. The first result after reset release comes from the first sampled i_valid=1 after release.
- Count definition: o_lzc = WIDTH-1-p, where p is the index of the highest set bit of i_data.
- Limits of the count:
  - Bit WIDTH-1 set gives 0.
  - Only bit 0 set gives WIDTH-1.
  - i_data=0 gives o_lzc=WIDTH and o_zero=1.
  - o_zero=0 whenever any input bit is set.
- Latency: exactly 1 cycle, fully pipelined, throughput 1 word per clock.
  - At each rising edge with i_valid=1: o_lzc and o_zero load the count of i_data, and o_valid becomes 1.
  - At each rising edge with i_valid=0: o_valid becomes 0, and o_lzc/o_zero hold their previous values (no update).
- No backpressure; no ready signal. Consecutive valid inputs produce consecutive results in order.
- i_data is treated as unsigned. Sign handling (two's-complement negation) is the caller's job.
  - Example: the most negative SQ12.12 value negates to 0x800000, which counts as 0.
- Count logic: a combinational priority encoder, either a log-depth tree of pairwise (zero-flag, count) merges or an equivalent.
  - Count bits above those needed are zero.
  - Result must be exact for every WIDTH in range, including non-power-of-two widths.
  - For widths that are not a power of two, pad with ones on the LSB side, so the padding cannot add to the count.
- No X propagation from unused internal padding onto the outputs.

Test Plan:
- Reset asserted asynchronously between edges, with a result already held → o_valid, o_lzc and o_zero drop to 0 without waiting for a clock edge. After release, with i_valid=0, o_valid stays 0.
- WIDTH=24, single-pulse sequence:
  - i_data=0x800000 → o_lzc=0.
  - 0x001000 (1.0 in Q12.12) → o_lzc=11.
  - 0x000800 (0.5) → 12.
  - 0x000001 → 23.
  - Each result appears with o_valid=1 exactly one cycle after its i_valid, and o_zero=0 for all four.
- i_data=0x000000 with i_valid=1 → next cycle o_lzc=24, o_zero=1, o_valid=1.
- Back-to-back valid stream 0x400000, 0x0000FF, 0x7FFFFF, 0x000000 → results 1, 16, 1, 24 on consecutive cycles, with o_valid held high throughout.
- i_valid=0 for one cycle with i_data changed to 0x000010 → o_valid=0 and o_lzc still shows the previous count. The next i_valid=1 with 0x000010 → 19.
- Exhaustive walking-one sweep: for every bit k in 0..23, with random lower bits below k → o_lzc=23-k.
  - Repeat with WIDTH=20 and CNT_W=5: i_data=0x00001 → 19, and all-zero → 20.

Source files
------------

// File: rtl/leading_zero_counter.sv
// leading_zero_counter
//
// Registered leading-zero counter over a WIDTH-bit unsigned word. It reports
// how many zero bits sit above the most-significant 1, counting down from
// bit WIDTH-1. The count drives the normalisation shift of the fixed-point
// reciprocal unit, which scales its input into the [0.5,1) range.
//
// Parameters:
//   WIDTH  input word width, 2..64 (default 24, an SQ12.12 magnitude)
//   CNT_W  count width, 2**CNT_W must exceed WIDTH (default 5)
//
// Ports:
//   clk      system clock, rising-edge active
//   reset    asynchronous, active-high reset
//   i_valid  i_data is to be counted this cycle
//   i_data   unsigned word, bit WIDTH-1 is the MSB
//   o_valid  o_lzc/o_zero hold a fresh result (one cycle after i_valid)
//   o_lzc    leading-zero count of the captured word (WIDTH when all zero)
//   o_zero   captured word was all zeros
//
// Timing: one-cycle latency, one word per clock, no backpressure. With
// i_valid low the result registers hold and only o_valid drops.

module leading_zero_counter #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_lzc,
  output logic             o_zero
);

  // The tree works on a power-of-two word. Narrower inputs are padded with
  // ones below the LSB, so an all-zero input naturally counts to WIDTH and
  // the padding can never add to a non-zero count.
  localparam int L   = $clog2(WIDTH);
  localparam int P   = 1 << L;
  localparam int PAD = P - WIDTH;
  localparam int TW  = L;

  logic [P-1:0] padded;

  generate
    if (PAD > 0) begin : g_pad
      assign padded = {i_data, {PAD{1'b1}}};
    end else begin : g_nopad
      assign padded = i_data;
    end
  endgenerate

  // Heap-ordered binary tree: node 1 is the root, node k has children 2k
  // (the more significant half) and 2k+1. Leaves P..2P-1 map to bits
  // P-1 down to 0. Each node carries "my span is all zero" and "leading
  // zeros within my span".
  logic          node_z [1:2*P-1];
  logic [TW-1:0] node_c [1:2*P-1];

  generate
    for (genvar i = 0; i < P; i++) begin : g_leaf
      assign node_z[P+i] = ~padded[P-1-i];
      assign node_c[P+i] = '0;
    end

    for (genvar k = 1; k < P; k++) begin : g_node
      // Depth of node k below the root, and the bit span of each child.
      localparam int            DEPTH = $clog2(k + 1) - 1;
      localparam logic [TW-1:0] HALF  = TW'(P >> (DEPTH + 1));

      // A zero upper half means all its bits lead, then the lower half counts on.
      assign node_z[k] = node_z[2*k] & node_z[2*k+1];
      assign node_c[k] = node_z[2*k] ? (HALF + node_c[2*k+1]) : node_c[2*k];
    end
  endgenerate

  logic             valid_d, valid_q;
  logic [CNT_W-1:0] lzc_d,   lzc_q;
  logic             zero_d,  zero_q;

  // Next-state: load a new count on a valid word, otherwise hold the last
  // result and only drop the valid flag. The root zero flag can only be set
  // when there is no padding, in which case the count is forced to WIDTH.
  always_comb begin
    valid_d = i_valid;
    lzc_d   = lzc_q;
    zero_d  = zero_q;
    if (i_valid) begin
      lzc_d  = node_z[1] ? CNT_W'(WIDTH) : CNT_W'(node_c[1]);
      zero_d = ~|i_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      lzc_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      lzc_q   <= lzc_d;
      zero_q  <= zero_d;
    end
  end

  assign o_valid = valid_q;
  assign o_lzc   = lzc_q;
  assign o_zero  = zero_q;

endmodule

// File: tb/tb_leading_zero_counter.sv
// Testbench for leading_zero_counter. Two instances: the default 24-bit
// unit and a 20-bit unit exercising the non-power-of-two padding path.
// Stimulus pushes hand-computed expectations into per-instance queues; a
// monitor on each instance pops and compares whenever o_valid is seen.

module tb_leading_zero_counter;

  typedef struct {
    int lzc;
    int zero;
    int cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        i_valid;
  logic [23:0] i_data;
  logic        o_valid;
  logic [4:0]  o_lzc;
  logic        o_zero;

  logic        i_valid20;
  logic [19:0] i_data20;
  logic        o_valid20;
  logic [4:0]  o_lzc20;
  logic        o_zero20;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t q24[$];
  exp_t q20[$];

  leading_zero_counter #(.WIDTH(24), .CNT_W(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_lzc   (o_lzc),
    .o_zero  (o_zero)
  );

  leading_zero_counter #(.WIDTH(20), .CNT_W(5)) dut20 (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid20),
    .i_data  (i_data20),
    .o_valid (o_valid20),
    .o_lzc   (o_lzc20),
    .o_zero  (o_zero20)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to tag when each result is due.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle on the 24-bit unit (inputs change 1 unit after the edge);
  // on a valid word the expected count is queued, due one cycle later.
  task automatic applyStimulus(input logic v, input logic [23:0] d, input int exp_lzc, input int exp_zero);
    exp_t e;
    @(posedge clk);
    #1;
    i_valid = v;
    i_data  = d;
    if (v) begin
      e.lzc  = exp_lzc;
      e.zero = exp_zero;
      e.cyc  = cyc + 1;
      q24.push_back(e);
    end
  endtask

  task automatic applyStimulus20(input logic v, input logic [19:0] d, input int exp_lzc, input int exp_zero);
    exp_t e;
    @(posedge clk);
    #1;
    i_valid20 = v;
    i_data20  = d;
    if (v) begin
      e.lzc  = exp_lzc;
      e.zero = exp_zero;
      e.cyc  = cyc + 1;
      q20.push_back(e);
    end
  endtask

  // Monitors: sample mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && o_valid) begin
      if (q24.size() == 0) begin
        checkOutput("w24 unexpected o_valid", 1, 0);
      end else begin
        e = q24.pop_front();
        checkOutput("w24 o_lzc", int'(o_lzc), e.lzc);
        checkOutput("w24 o_zero", int'(o_zero), e.zero);
        checkOutput("w24 result cycle", cyc, e.cyc);
      end
    end else if (q24.size() > 0 && q24[0].cyc < cyc) begin
      e = q24.pop_front();
      checkOutput("w24 missing o_valid at cycle", cyc, e.cyc);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && o_valid20) begin
      if (q20.size() == 0) begin
        checkOutput("w20 unexpected o_valid", 1, 0);
      end else begin
        e = q20.pop_front();
        checkOutput("w20 o_lzc", int'(o_lzc20), e.lzc);
        checkOutput("w20 o_zero", int'(o_zero20), e.zero);
        checkOutput("w20 result cycle", cyc, e.cyc);
      end
    end else if (q20.size() > 0 && q20[0].cyc < cyc) begin
      e = q20.pop_front();
      checkOutput("w20 missing o_valid at cycle", cyc, e.cyc);
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [23:0] mask;
    logic [23:0] word;

    reset     = 1'b1;
    i_valid   = 1'b0;
    i_data    = '0;
    i_valid20 = 1'b0;
    i_data20  = '0;

    // Reset state before any clock edge.
    #2;
    checkOutput("reset o_valid", int'(o_valid), 0);
    checkOutput("reset o_lzc", int'(o_lzc), 0);
    checkOutput("reset o_zero", int'(o_zero), 0);

    // Release reset mid-cycle, idle for two cycles.
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 24'h000000, 0, 0);
    applyStimulus(1'b0, 24'h000000, 0, 0);
    #3;
    checkOutput("idle after reset o_valid", int'(o_valid), 0);

    // Single pulses with idle cycles in between.
    applyStimulus(1'b1, 24'h800000, 0, 0);
    applyStimulus(1'b0, 24'h800000, 0, 0);
    applyStimulus(1'b1, 24'h001000, 11, 0);
    applyStimulus(1'b0, 24'h001000, 0, 0);
    applyStimulus(1'b1, 24'h000800, 12, 0);
    applyStimulus(1'b0, 24'h000800, 0, 0);
    applyStimulus(1'b1, 24'h000001, 23, 0);
    applyStimulus(1'b0, 24'h000001, 0, 0);

    // All-zero word.
    applyStimulus(1'b1, 24'h000000, 24, 1);
    applyStimulus(1'b0, 24'h000000, 0, 0);

    // Back-to-back stream.
    applyStimulus(1'b1, 24'h400000, 1, 0);
    applyStimulus(1'b1, 24'h0000FF, 16, 0);
    applyStimulus(1'b1, 24'h7FFFFF, 1, 0);
    applyStimulus(1'b1, 24'h000000, 24, 1);

    // Idle with changed data: result must hold at 24 / zero.
    applyStimulus(1'b0, 24'h000010, 0, 0);
    @(posedge clk);
    #3;
    checkOutput("hold o_valid", int'(o_valid), 0);
    checkOutput("hold o_lzc", int'(o_lzc), 24);
    checkOutput("hold o_zero", int'(o_zero), 1);
    @(negedge clk);
    i_valid = 1'b1;
    begin
      exp_t e;
      e.lzc  = 19;
      e.zero = 0;
      e.cyc  = cyc + 1;
      q24.push_back(e);
    end

    // Walking-one sweep with random bits below the leading one.
    for (int k = 0; k < 24; k++) begin
      mask = (24'h1 << k) - 24'h1;
      word = (24'h1 << k) | (24'($urandom) & mask);
      applyStimulus(1'b1, word, 23 - k, 0);
    end
    applyStimulus(1'b0, 24'h000000, 0, 0);

    // 20-bit instance: padding must not disturb the count.
    applyStimulus20(1'b1, 20'h00001, 19, 0);
    applyStimulus20(1'b1, 20'h00000, 20, 1);
    applyStimulus20(1'b1, 20'h80000, 0, 0);
    applyStimulus20(1'b1, 20'h00F0F, 8, 0);
    applyStimulus20(1'b0, 20'h00000, 0, 0);

    // Asynchronous reset between edges with a result held.
    applyStimulus(1'b1, 24'h000800, 12, 0);
    applyStimulus(1'b0, 24'h000000, 0, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async reset o_valid", int'(o_valid), 0);
    checkOutput("async reset o_lzc", int'(o_lzc), 0);
    checkOutput("async reset o_zero", int'(o_zero), 0);
    checkOutput("async reset w20 o_lzc", int'(o_lzc20), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 24'h000000, 0, 0);
    #3;
    checkOutput("post-reset idle o_valid", int'(o_valid), 0);

    // First result after release.
    applyStimulus(1'b1, 24'h000800, 12, 0);
    applyStimulus(1'b0, 24'h000000, 0, 0);
    applyStimulus(1'b0, 24'h000000, 0, 0);
    applyStimulus(1'b0, 24'h000000, 0, 0);

    checkOutput("w24 pending results left", q24.size(), 0);
    checkOutput("w20 pending results left", q20.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
